// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI burst write master.
// State encoding, AXI burst/response constants and the AWSIZE helper.
package axi_wr_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AW   = 3'd1,
      W    = 3'd2,
      B    = 3'd3,
      NEXT = 3'd4,
      DONE = 3'd5
   } wr_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // log2 of the bus width in bytes, as carried on AWSIZE
   function automatic logic [2:0] axi_size(input int unsigned data_width);
      case (data_width)
         16:      axi_size = 3'd1;
         32:      axi_size = 3'd2;
         64:      axi_size = 3'd3;
         default: axi_size = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/axi_burst_wr_master_if.sv
// AXI write-channel bundle (AW, W, B) between the burst master and a slave.
interface axi_burst_wr_master_if #(
   parameter int ADDR_WIDTH = 27,
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     axi_awid;
   logic                    axi_awvalid;
   logic                    axi_awready;
   logic [ADDR_WIDTH-1:0]   axi_awaddr;
   logic [7:0]              axi_awlen;
   logic [2:0]              axi_awsize;
   logic [1:0]              axi_awburst;
   logic                    axi_wvalid;
   logic                    axi_wready;
   logic [DATA_WIDTH-1:0]   axi_wdata;
   logic [DATA_WIDTH/8-1:0] axi_wstrb;
   logic                    axi_wlast;
   logic                    axi_bvalid;
   logic                    axi_bready;
   logic [1:0]              axi_bresp;

   modport master (
      output axi_awid, axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
      output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
      input  axi_awready, axi_wready, axi_bvalid, axi_bresp
   );

   modport slave (
      input  axi_awid, axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
      input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
      output axi_awready, axi_wready, axi_bvalid, axi_bresp
   );
endinterface

// File: rtl/axi_burst_calc.sv
// Burst length for the next AXI burst: the smallest of the beats still to
// send, MAX_BURST, and the beats left before the next 4 KB boundary.
module axi_burst_calc
   import axi_wr_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 16
) (
   input  logic [11:0] addr_lo,
   input  logic [15:0] remaining,
   output logic [15:0] burst_len
);

   localparam int SIZE = int'(axi_size(DATA_WIDTH));

   logic [12:0] to_4k_bytes;
   logic [12:0] to_4k_beats;

   // Clamp the remaining beat count by the burst cap and the 4 KB page edge
   always_comb begin
      to_4k_bytes = 13'd4096 - {1'b0, addr_lo};
      to_4k_beats = to_4k_bytes >> SIZE;
      burst_len   = remaining;
      if (burst_len > 16'(MAX_BURST))
         burst_len = 16'(MAX_BURST);
      if (burst_len > {3'b000, to_4k_beats})
         burst_len = {3'b000, to_4k_beats};
   end

endmodule

// File: rtl/axi_burst_wr_master.sv
// AXI4 burst write master: splits a user write of wr_len beats into INCR
// bursts that respect MAX_BURST and 4 KB boundaries, streams wr_data as
// W beats and collects B responses into a sticky error flag.
// Optional feature macro: AXI_WR_TIMEOUT_EN (B-channel watchdog).
module axi_burst_wr_master
   import axi_wr_pkg::*;
#(
   parameter int                ADDR_WIDTH  = 27,
   parameter int                DATA_WIDTH  = 16,
   parameter int                MAX_BURST   = 16,
   parameter int                ID_WIDTH    = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID    = '0,
   parameter int                TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_end,
   input  logic                  wr_trig,
   input  logic [15:0]           wr_len,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_data_en,
   output logic                  wr_ready,
   output logic                  wr_done,
   output logic                  wr_err,
   axi_burst_wr_master_if.master axi
);

   localparam int SIZE = int'(axi_size(DATA_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

   wr_state_t             state, nxt;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [15:0]           rem_r;
   logic [15:0]           blen_r;
   logic [7:0]            awlen_r;
   logic [15:0]           beat_cnt;
   logic                  err_r;

   logic                  accept;
   logic                  last_beat;
   logic [ADDR_WIDTH-1:0] burst_bytes;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [15:0]           next_rem;
   logic [ADDR_WIDTH-1:0] calc_addr;
   logic [15:0]           calc_rem;
   logic [15:0]           calc_len;
   logic                  to_hit;

   assign accept      = wr_trig & init_end;
   assign last_beat   = (beat_cnt == blen_r - 16'd1);
   assign burst_bytes = ADDR_WIDTH'(blen_r) << SIZE;
   assign next_addr   = addr_r + burst_bytes;
   assign next_rem    = rem_r - blen_r;

   // Burst planner input: the new request in IDLE, the advanced position in NEXT
   always_comb begin
      calc_addr = addr_r;
      calc_rem  = rem_r;
      if (state == IDLE) begin
         calc_addr = wr_addr & ALIGN_MASK;
         calc_rem  = wr_len;
      end else if (state == NEXT) begin
         calc_addr = next_addr;
         calc_rem  = next_rem;
      end
   end

   axi_burst_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_BURST  (MAX_BURST)
   ) u_calc (
      .addr_lo   (calc_addr[11:0]),
      .remaining (calc_rem),
      .burst_len (calc_len)
   );

`ifdef AXI_WR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;

   assign to_hit = (state == B) && !axi.axi_bvalid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // Watchdog: count cycles spent in B waiting for a response
   always_ff @(posedge clk) begin
      if (!rst_n || state != B)
         to_cnt <= '0;
      else if (!axi.axi_bvalid)
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt;
   end

   // Next-state decode and handshake strobes
   always_comb begin
      nxt             = state;
      wr_ready        = 1'b0;
      wr_done         = 1'b0;
      axi.axi_awvalid = 1'b0;
      axi.axi_wvalid  = 1'b0;
      axi.axi_bready  = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = 1'b1;
            if (accept)
               nxt = (wr_len == 16'd0) ? DONE : AW;
         end
         AW: begin
            axi.axi_awvalid = 1'b1;
            if (axi.axi_awready)
               nxt = W;
         end
         W: begin
            axi.axi_wvalid = 1'b1;
            if (axi.axi_wready && last_beat)
               nxt = B;
         end
         B: begin
            axi.axi_bready = 1'b1;
            if (axi.axi_bvalid)
               nxt = NEXT;
            else if (to_hit)
               nxt = DONE;
         end
         NEXT: nxt = (next_rem != 16'd0) ? AW : DONE;
         DONE: begin
            wr_done = 1'b1;
            nxt     = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Burst position, beat counter and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r   <= '0;
         rem_r    <= '0;
         blen_r   <= '0;
         awlen_r  <= '0;
         beat_cnt <= '0;
         err_r    <= 1'b0;
      end else begin
         if (state == IDLE && accept)
            err_r <= 1'b0;
         if ((state == IDLE || state == NEXT) && nxt == AW) begin
            addr_r  <= calc_addr;
            rem_r   <= calc_rem;
            blen_r  <= calc_len;
            awlen_r <= 8'(calc_len - 16'd1);
         end
         if (state == W && axi.axi_wready)
            beat_cnt <= last_beat ? 16'd0 : beat_cnt + 16'd1;
         if (state == B && axi.axi_bvalid && axi.axi_bresp != AXI_RESP_OKAY)
            err_r <= 1'b1;
         if (to_hit)
            err_r <= 1'b1;
      end
   end

   assign axi.axi_awid    = AXI_ID;
   assign axi.axi_awaddr  = addr_r;
   assign axi.axi_awlen   = awlen_r;
   assign axi.axi_awsize  = axi_size(DATA_WIDTH);
   assign axi.axi_awburst = AXI_BURST_INCR;
   assign axi.axi_wdata   = wr_data;
   assign axi.axi_wstrb   = '1;
   assign axi.axi_wlast   = (state == W) && last_beat;
   assign wr_data_en      = axi.axi_wvalid & axi.axi_wready;
   assign wr_err          = err_r;

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Testbench for axi_burst_wr_master: directed transfers against a burst
// planning model, with a slave responder and per-cycle output checks.
module tb_axi_burst_wr_master;

   localparam int AW_W = 27;

   typedef struct {
      longint addr;
      int     len;
   } burst_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            init_end = 1'b1;
   logic            wr_trig = 1'b0;
   logic [15:0]     wr_len = '0;
   logic [AW_W-1:0] wr_addr = '0;
   logic [15:0]     wr_data = '0;
   logic            wr_data_en, wr_ready, wr_done, wr_err;

   axi_burst_wr_master_if #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(16), .ID_WIDTH(4)) bus ();

   axi_burst_wr_master #(
      .ADDR_WIDTH (AW_W), .DATA_WIDTH (16), .MAX_BURST (16),
      .ID_WIDTH (4), .AXI_ID (4'h5), .TIMEOUT_CYC (16)
   ) dut (
      .clk (clk), .rst_n (rst_n), .init_end (init_end), .wr_trig (wr_trig),
      .wr_len (wr_len), .wr_addr (wr_addr), .wr_data (wr_data),
      .wr_data_en (wr_data_en), .wr_ready (wr_ready), .wr_done (wr_done),
      .wr_err (wr_err), .axi (bus.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model / scoreboard state
   burst_t exp_q[$];
   int     w_q[$];
   longint obs_addr[$];
   int     obs_len[$];
   int     beat_i = 0, pend_b = 0, b_idx = 0, err_idx = -1;
   int     beats_seen = 0, en_cnt = 0, last_wlast_beat = 0, b_cycles = 0, done_cnt = 0;
   bit     exp_err = 0, to_exp = 0, busy = 0, stall = 0, b_hold = 0;
   bit     prev_aw_stall = 0, prev_done = 0, last_done_err = 0;
   longint prev_awaddr = 0, prev_awlen = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plan bursts from the rules: align, then min(rest, 16, beats to 4 KB)
   function automatic void plan(input longint a0, input int len);
      longint a = a0 - (a0 % 2);
      int     rem = len;
      while (rem > 0) begin
         int b = rem;
         int to4k = int'((4096 - (a % 4096)) / 2);
         burst_t bt;
         if (b > 16) b = 16;
         if (b > to4k) b = to4k;
         bt.addr = a;
         bt.len  = b;
         exp_q.push_back(bt);
         a   = (a + 2 * b) % (longint'(1) << AW_W);
         rem = rem - b;
      end
   endfunction

   task automatic flush_model();
      exp_q.delete();
      w_q.delete();
      beat_i = 0; pend_b = 0; busy = 0; exp_err = 0;
      prev_aw_stall = 0; prev_done = 0;
   endtask

   // One clock: drive slave inputs at negedge, then check what the next posedge sees
   task automatic step();
      @(negedge clk);
      bus.axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.axi_bvalid  = (pend_b > 0) && !b_hold;
      bus.axi_bresp   = (b_idx == err_idx) ? 2'b10 : 2'b00;
      wr_data         = 16'($urandom);
      #1;
      chk("wr_data_en", wr_data_en, bus.axi_wvalid & bus.axi_wready);
      chk("wr_ready", wr_ready, !busy);
      if (wr_data_en) en_cnt++;
      if (bus.axi_wvalid) begin
         chk("wdata", bus.axi_wdata, wr_data);
         chk("wstrb", bus.axi_wstrb, 2'b11);
      end
      if (rst_n) begin
         if (prev_aw_stall) begin
            chk("aw_hold_valid", bus.axi_awvalid, 1);
            chk("aw_hold_addr", bus.axi_awaddr, prev_awaddr);
            chk("aw_hold_len", bus.axi_awlen, prev_awlen);
         end
         if (bus.axi_awvalid && bus.axi_awready) begin
            obs_addr.push_back(bus.axi_awaddr);
            obs_len.push_back(bus.axi_awlen);
            chk("awsize", bus.axi_awsize, 1);
            chk("awburst", bus.axi_awburst, 1);
            chk("awid", bus.axi_awid, 5);
            if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               burst_t bt = exp_q.pop_front();
               chk("awaddr", bus.axi_awaddr, bt.addr);
               chk("awlen", bus.axi_awlen, bt.len - 1);
               w_q.push_back(bt.len);
            end
         end
         if (bus.axi_wvalid && bus.axi_wready) begin
            beats_seen++;
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               bit last = (beat_i == w_q[0] - 1);
               chk("wlast", bus.axi_wlast, last);
               beat_i++;
               if (last) begin
                  void'(w_q.pop_front());
                  beat_i = 0;
                  pend_b++;
                  last_wlast_beat = beats_seen;
               end
            end
         end
         if (bus.axi_bvalid && bus.axi_bready) begin
            pend_b--;
            if (bus.axi_bresp != 2'b00) exp_err = 1;
            b_idx++;
         end
         if (bus.axi_bready) b_cycles++;
         if (wr_done) begin
            done_cnt++;
            last_done_err = wr_err;
            chk("done_err", wr_err, exp_err | to_exp);
            chk("done_complete", exp_q.size() + w_q.size(), 0);
            chk("done_single", prev_done, 0);
            busy = 0;
         end
      end
      prev_aw_stall = bus.axi_awvalid && !bus.axi_awready;
      prev_awaddr   = bus.axi_awaddr;
      prev_awlen    = bus.axi_awlen;
      prev_done     = wr_done;
   endtask

   task automatic start_xfer(input longint a, input int len);
      obs_addr.delete();
      obs_len.delete();
      b_cycles = 0; beats_seen = 0; en_cnt = 0; b_idx = 0; exp_err = 0;
      last_done_err = 0; last_wlast_beat = 0;
      plan(a, len);
      wr_addr = AW_W'(a);
      wr_len  = 16'(len);
      wr_trig = 1'b1;
      busy    = 1;
      step();
      wr_trig = 1'b0;
   endtask

   task automatic run_xfer(input longint a, input int len);
      int d0 = done_cnt;
      int n = 0;
      start_xfer(a, len);
      while (done_cnt == d0 && n < 3000) begin
         step();
         n++;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      step();
   endtask

   initial begin
      bus.axi_awready = 1'b1;
      bus.axi_wready  = 1'b1;
      bus.axi_bvalid  = 1'b0;
      bus.axi_bresp   = 2'b00;

      // reset state
      repeat (3) step();
      chk("rst_awvalid", bus.axi_awvalid, 0);
      chk("rst_wvalid", bus.axi_wvalid, 0);
      chk("rst_bready", bus.axi_bready, 0);
      chk("rst_done", wr_done, 0);
      chk("rst_err", wr_err, 0);
      chk("rst_awaddr", bus.axi_awaddr, 0);
      chk("rst_awlen", bus.axi_awlen, 0);
      rst_n = 1'b1;
      step();

      // trigger ignored while memory not ready
      init_end = 1'b0;
      wr_len = 16'd8;
      wr_trig = 1'b1;
      repeat (3) step();
      chk("noinit_ready", wr_ready, 1);
      chk("noinit_awvalid", bus.axi_awvalid, 0);
      wr_trig = 1'b0;
      init_end = 1'b1;
      step();

      // single 8-beat burst at 0x100
      run_xfer(64'h100, 8);
      chk("t1_bursts", obs_len.size(), 1);
      chk("t1_awaddr", obs_addr[0], 64'h100);
      chk("t1_awlen", obs_len[0], 7);
      chk("t1_en_pulses", en_cnt, 8);
      chk("t1_wlast_beat", last_wlast_beat, 8);
      chk("t1_err", last_done_err, 0);

      // 40 beats from 0: 16/16/8
      run_xfer(64'h0, 40);
      chk("t2_bursts", obs_len.size(), 3);
      chk("t2_addr0", obs_addr[0], 64'h000);
      chk("t2_addr1", obs_addr[1], 64'h020);
      chk("t2_addr2", obs_addr[2], 64'h040);
      chk("t2_len0", obs_len[0], 15);
      chk("t2_len1", obs_len[1], 15);
      chk("t2_len2", obs_len[2], 7);

      // 4 KB split
      run_xfer(64'hFF8, 8);
      chk("t3_bursts", obs_len.size(), 2);
      chk("t3_addr0", obs_addr[0], 64'hFF8);
      chk("t3_len0", obs_len[0], 3);
      chk("t3_addr1", obs_addr[1], 64'h1000);
      chk("t3_len1", obs_len[1], 3);

      // unaligned start address is aligned down
      run_xfer(64'h101, 3);
      chk("t4_addr", obs_addr[0], 64'h100);
      chk("t4_len", obs_len[0], 2);

      // address wraps at 2^27
      run_xfer(64'h7FFFFF0, 16);
      chk("t5_bursts", obs_len.size(), 2);
      chk("t5_addr1", obs_addr[1], 64'h0);
      chk("t5_len0", obs_len[0], 7);

      // error on first of two bursts: second still issued, error held
      err_idx = 0;
      run_xfer(64'h0, 32);
      chk("t6_bursts", obs_len.size(), 2);
      chk("t6_done_err", last_done_err, 1);
      step();
      chk("t6_err_held", wr_err, 1);
      err_idx = -1;

      // random stalls across a 4 KB split
      stall = 1;
      run_xfer(64'hFF0, 40);
      chk("t7_bursts", obs_len.size(), 3);
      chk("t7_beats", beats_seen, 40);

      // reset in the middle of the second burst's W phase
      begin
         int n = 0;
         int d0, nobs;
         err_idx = 0;
         start_xfer(64'h200, 40);
         while (!(b_idx >= 1 && bus.axi_wvalid) && n < 3000) begin
            step();
            n++;
         end
         chk("t8_reached_w", bus.axi_wvalid, 1);
         rst_n = 1'b0;
         flush_model();
         step();
         chk("t8_awvalid", bus.axi_awvalid, 0);
         chk("t8_wvalid", bus.axi_wvalid, 0);
         chk("t8_bready", bus.axi_bready, 0);
         chk("t8_ready", wr_ready, 1);
         chk("t8_done", wr_done, 0);
         chk("t8_err", wr_err, 0);
         chk("t8_awaddr", bus.axi_awaddr, 0);
         rst_n = 1'b1;
         stall = 0;
         err_idx = -1;
         d0 = done_cnt;
         nobs = obs_addr.size();
         repeat (20) step();
         chk("t8_no_done", done_cnt, d0);
         chk("t8_no_resume", obs_addr.size(), nobs);
      end

      // zero-length transfer: done without bus activity
      run_xfer(64'h40, 0);
      chk("t9_bursts", obs_len.size(), 0);
      chk("t9_err", last_done_err, 0);

`ifdef AXI_WR_TIMEOUT_EN
      // B watchdog: no response ever comes
      b_hold = 1;
      to_exp = 1;
      run_xfer(64'h0, 4);
      chk("t10_b_cycles", b_cycles, 16);
      chk("t10_err", last_done_err, 1);
      b_hold = 0;
      to_exp = 0;
      pend_b = 0;
      run_xfer(64'h80, 0);
      chk("t10_zero_bursts", obs_len.size(), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_burst_wr_master.md
AXI_BURST_WR_MASTER -- requirements
Module: axi_burst_wr_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width; legal values 16/32/64.
REQ-003 SHALL have parameter MAX_BURST, default 16, max beats per AXI burst; legal range 1..256.
REQ-004 SHALL have parameter ID_WIDTH, default 4, and parameter AXI_ID, default 0, constant AWID value.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, B-channel watchdog limit.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-007 SHALL have ports: init_end in 1 memory ready; wr_trig in 1 start; wr_len in 16 total beats; wr_addr in ADDR_WIDTH start byte address.
REQ-008 SHALL have ports: wr_data in DATA_WIDTH user data; wr_data_en out 1 data consumed; wr_ready out 1 idle; wr_done out 1 completion pulse; wr_err out 1 error status.
REQ-009 SHALL have AW ports: axi_awid out ID_WIDTH; axi_awvalid out 1; axi_awready in 1; axi_awaddr out ADDR_WIDTH; axi_awlen out 8; axi_awsize out 3; axi_awburst out 2.
REQ-010 SHALL have W/B ports: axi_wvalid out 1; axi_wready in 1; axi_wdata out DATA_WIDTH; axi_wstrb out DATA_WIDTH/8; axi_wlast out 1; axi_bvalid in 1; axi_bready out 1; axi_bresp in 2.

Function
REQ-011 SHALL implement states IDLE, AW, W, B, NEXT, DONE.
REQ-012 SHALL accept wr_trig only in IDLE with init_end=1; otherwise wr_trig is ignored.
REQ-013 SHALL, on accepting wr_trig, latch wr_addr aligned down to DATA_WIDTH/8 bytes and latch wr_len; when wr_len=0, go straight to DONE with no bus activity.
REQ-014 SHALL compute each burst length as min(remaining beats, MAX_BURST, beats left to the next 4 KB boundary).
REQ-015 SHALL drive axi_awlen = burst length - 1, axi_awsize = log2(DATA_WIDTH/8), axi_awburst = 2'b01 (INCR), axi_awid = AXI_ID, axi_wstrb all ones.
REQ-016 SHALL assert axi_awvalid in AW and hold it, with awaddr/awlen stable, until axi_awready; then move to W.
REQ-017 SHALL assert axi_wvalid throughout W, with axi_wdata = wr_data combinationally, and wr_data_en = axi_wvalid & axi_wready.
REQ-018 SHALL assert axi_wlast only on the last beat of each burst; on wlast handshake, drop wvalid and move to B.
REQ-019 SHALL assert axi_bready only in B; on axi_bvalid, OR (axi_bresp != 2'b00) into a sticky error flag and move to NEXT.
REQ-020 SHALL in NEXT advance address by burst bytes and decrement remaining; go to AW if remaining > 0, else DONE.
REQ-021 SHALL continue all remaining bursts after an error response; no abort.
REQ-022 SHALL pulse wr_done for exactly one cycle in DONE, with wr_err valid in that cycle and held until the next accepted wr_trig; then return to IDLE.
REQ-023 SHALL drive wr_ready = 1 only in IDLE.
REQ-024 SHALL keep address arithmetic at ADDR_WIDTH bits, wrapping modulo 2^ADDR_WIDTH.

Reset
REQ-025 SHALL, on rst_n=0 at a clk edge, enter IDLE from any state, including mid-burst, and clear axi_awvalid, axi_wvalid, axi_bready, wr_done, wr_err, internal counters and axi_awaddr/axi_awlen to 0.
REQ-026 SHALL NOT complete or resume an interrupted transfer after reset.

Configuration
REQ-027 SHALL support macro AXI_WR_TIMEOUT_EN: when defined, if TIMEOUT_CYC cycles elapse in B without axi_bvalid, set wr_err and go to DONE.
REQ-028 SHALL, without AXI_WR_TIMEOUT_EN, wait in B indefinitely and include no watchdog logic.

Structure
REQ-029 SHALL place the state enum, the AXI_BURST_INCR and AXI_RESP_OKAY constants and the awsize function in shared package axi_wr_pkg.
REQ-030 SHALL place the burst-length and 4 KB boundary calculation in sub-module axi_burst_calc.

Verification
REQ-031 SHALL cover: wr_len=8, addr 0x100, awready/wready always 1 -> one burst, awlen=7, 8 wr_data_en pulses, wlast on beat 8, wr_done=1, wr_err=0.
REQ-032 SHALL cover: wr_len=40, MAX_BURST=16, addr 0 -> bursts of 16/16/8, awaddr 0x000/0x020/0x040 (16-bit bus).
REQ-033 SHALL cover: addr 0xFF8, wr_len=8, 16-bit bus -> bursts of 4 beats at 0xFF8 and 4 beats at 0x1000.
REQ-034 SHALL cover: bresp=2'b10 on the first of two bursts -> second burst still issued; wr_done with wr_err=1.
REQ-035 SHALL cover: random wready/awready stalls, with rst_n asserted mid-W -> all valids 0 next cycle, wr_ready=1, no wr_done.
REQ-036 SHALL cover: with AXI_WR_TIMEOUT_EN, TIMEOUT_CYC=16 and bvalid held 0 -> wr_done and wr_err after 16 cycles in B; wr_len=0 -> wr_done with no awvalid.
